// File: rtl/round_robin_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin arbiter.
package round_robin_arbiter_pkg;

    localparam int unsigned NumReq     = 8;
    localparam int unsigned IdxW       = 3;
    localparam int unsigned DefMaxHold = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StGap   = 2'b10
    } state_e;

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface round_robin_arbiter_if
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = NumReq
) ();

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IdxW-1:0]  gnt_id;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/round_robin_arbiter_prio_enc_rot.sv
// Rotated priority search: first set bit of req starting at ptr, wrapping modulo NumReq.
module prio_enc_rot
    import round_robin_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   idx,
    output logic              found
);

    logic [2*NumReq-1:0] req_dbl;
    logic [NumReq-1:0]   req_rot;
    logic [IdxW-1:0]     offset;

    // Doubling the vector turns the wrap-around into a plain part-select.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NumReq];

    always_comb begin
        offset = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IdxW'(i);
            end
        end
    end

    assign idx   = ptr + offset;
    assign found = |req;

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with one-cycle gap between owners and optional hold timeout.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = NumReq,
    parameter int unsigned MAX_HOLD = DefMaxHold
) (
    input logic                  clk,
    input logic                  rst,
    round_robin_arbiter_if.slave bus
);

    localparam int unsigned     CntW     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam bit              HoldEn   = (MAX_HOLD != 0);
    localparam logic [CntW-1:0] HoldLast = HoldEn ? CntW'(MAX_HOLD - 1) : '0;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [IdxW-1:0]  win_idx;
    logic             win_found;
    logic             owner_req;
    logic             hit_last;

    prio_enc_rot u_enc (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (win_idx),
        .found (win_found)
    );

    assign owner_req = bus.req[gnt_id_q];
    assign hit_last  = HoldEn && (cnt_q == HoldLast);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = '0;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            // IDLE and GAP arbitrate identically; ptr was already advanced on release.
            StIdle, StGap: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                if (win_found) begin
                    state_d          = StGrant;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_id_d         = win_idx;
                    gnt_valid_d      = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                if (bus.done || !owner_req || hit_last) begin
                    state_d     = StGap;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + 1'b1;
                    // A voluntary release in the same cycle masks the timeout.
                    timeout_d   = hit_last && !bus.done && owner_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: dut_a uses the default hold limit, dut_b a hold limit of 4 for timeout cases.
module tb_round_robin_arbiter;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    round_robin_arbiter_if bus_a ();
    round_robin_arbiter_if bus_b ();

    round_robin_arbiter #(
        .N_REQ    (8),
        .MAX_HOLD (16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    round_robin_arbiter #(
        .N_REQ    (8),
        .MAX_HOLD (4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Packed view {gnt, gnt_valid, gnt_id, timeout}; gnt_id is don't-care while invalid.
    function automatic logic [12:0] pack(input logic [7:0] g, input logic v,
                                         input logic [2:0] id, input logic to);
        return {g, v, (v ? id : 3'd0), to};
    endfunction

    function automatic logic [12:0] obs_a();
        return pack(bus_a.gnt, bus_a.gnt_valid, bus_a.gnt_id, bus_a.timeout);
    endfunction

    function automatic logic [12:0] obs_b();
        return pack(bus_b.gnt, bus_b.gnt_valid, bus_b.gnt_id, bus_b.timeout);
    endfunction

    function automatic logic [12:0] granted(input logic [7:0] g, input logic [2:0] id);
        return pack(g, 1'b1, id, 1'b0);
    endfunction

    function automatic logic [12:0] empty(input logic to);
        return pack(8'h00, 1'b0, 3'd0, to);
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed gnt=%h valid=%b id=%0d to=%b required gnt=%h valid=%b id=%0d to=%b",
                   tag, obs[12:5], obs[4], obs[3:1], obs[0], exp[12:5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] oh;

        rst          = 1'b1;
        bus_a.req    = '0;
        bus_a.done   = 1'b0;
        bus_b.req    = '0;
        bus_b.done   = 1'b0;

        tick();
        check("reset_a", obs_a(), empty(1'b0));
        check("reset_b", obs_b(), empty(1'b0));
        rst = 1'b0;

        tick();
        check("idle_no_req", obs_a(), empty(1'b0));
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        check("idle_done_ignored", obs_a(), empty(1'b0));

        // Single requester 2
        bus_a.req = 8'h04;
        tick();
        check("single_grant", obs_a(), granted(8'h04, 3'd2));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_hold", obs_a(), granted(8'h04, 3'd2));
        end
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        check("single_gap", obs_a(), empty(1'b0));
        tick();
        check("single_regrant", obs_a(), granted(8'h04, 3'd2));
        bus_a.req = 8'h00;
        tick();
        check("drop_gap", obs_a(), empty(1'b0));
        tick();
        check("drop_idle", obs_a(), empty(1'b0));

        // Rotation from ptr=0 with everyone requesting
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus_a.req = 8'hFF;
        tick();
        check("rot_first", obs_a(), granted(8'h01, 3'd0));
        for (int k = 1; k <= 8; k++) begin
            bus_a.done = 1'b1;
            tick();
            bus_a.done = 1'b0;
            check("rot_gap", obs_a(), empty(1'b0));
            tick();
            oh = 8'h01 << (k % 8);
            check("rot_grant", obs_a(), granted(oh, 3'(k % 8)));
        end

        // Wrap priority: owner 5 releases, ptr=6, req=0x41
        bus_a.req = 8'h20;
        tick();
        check("wrap_gap0", obs_a(), empty(1'b0));
        tick();
        check("wrap_own5", obs_a(), granted(8'h20, 3'd5));
        bus_a.req = 8'h41;
        tick();
        check("wrap_gap1", obs_a(), empty(1'b0));
        tick();
        check("wrap_own6", obs_a(), granted(8'h40, 3'd6));
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        check("wrap_gap2", obs_a(), empty(1'b0));
        tick();
        check("wrap_own0", obs_a(), granted(8'h01, 3'd0));

        // Non-owner request changes during a grant
        bus_a.req = 8'hC1;
        tick();
        check("nonowner_hold0", obs_a(), granted(8'h01, 3'd0));
        bus_a.req = 8'h03;
        tick();
        check("nonowner_hold1", obs_a(), granted(8'h01, 3'd0));

        // Reset in the middle of owner 5's grant
        bus_a.req = 8'h20;
        tick();
        check("mid_gap", obs_a(), empty(1'b0));
        tick();
        check("mid_own5", obs_a(), granted(8'h20, 3'd5));
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_clear", obs_a(), empty(1'b0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus_a.req = 8'h21;
        tick();
        check("post_reset_ptr0", obs_a(), granted(8'h01, 3'd0));

        // Timeout with MAX_HOLD=4
        bus_b.req = 8'h10;
        tick();
        check("to_grant", obs_b(), granted(8'h10, 3'd4));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_hold", obs_b(), granted(8'h10, 3'd4));
        end
        tick();
        check("to_pulse", obs_b(), empty(1'b1));
        tick();
        check("to_regrant", obs_b(), granted(8'h10, 3'd4));

        // done coinciding with the last hold cycle suppresses timeout
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sim_hold", obs_b(), granted(8'h10, 3'd4));
        end
        bus_b.done = 1'b1;
        tick();
        bus_b.done = 1'b0;
        check("sim_no_timeout", obs_b(), empty(1'b0));
        tick();
        check("sim_regrant", obs_b(), granted(8'h10, 3'd4));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cnt_cleared_hold", obs_b(), granted(8'h10, 3'd4));
        end
        tick();
        check("cnt_cleared_pulse", obs_b(), empty(1'b1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
